// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared defaults, index type and output-register states for the round-robin arbiter
package arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int REQ_IDX_W   = $clog2(NUM_REQ_DEF);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr, wrapping to 0
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(ptr) + 32'(i)) % 32'(NUM_REQ));
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// rtl/reg_rr_arbiter.sv - round-robin N:1 arbiter with a registered output stage
// Optional: REG_RR_ARBITER_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module reg_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    input  logic                      out_ready
);

    localparam int IDW = $clog2(NUM_REQ);

    out_state_t         state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     next_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDW-1:0]     pick_winner;
    logic               pick_any;
    logic [IDW-1:0]     winner;
    logic               any;
    logic               load;
    logic               ptr_upd;
    logic [DATA_W-1:0]  win_data;

`ifdef REG_RR_ARBITER_PRIO0_EN
    // Requester 0 bypasses the rotation; the pointer only tracks wins among 1..N-1.
    assign pick_mask = {req_valid[NUM_REQ-1:1], 1'b0};
    assign winner    = req_valid[0] ? '0 : pick_winner;
    assign any       = req_valid[0] | pick_any;
    assign ptr_upd   = load && (winner != '0);
`else
    assign pick_mask = req_valid;
    assign winner    = pick_winner;
    assign any       = pick_any;
    assign ptr_upd   = load;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (pick_mask),
        .ptr     (ptr),
        .winner  (pick_winner),
        .any     (pick_any)
    );

    assign load      = !rst && ((state == ST_EMPTY) || out_ready) && any;
    assign req_ready = load ? (NUM_REQ'(1) << winner) : '0;
    assign next_ptr  = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (load) begin
            // Covers both the empty fill and the drain-and-refill case.
            state     <= ST_FULL;
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_id    <= winner;
        end else if ((state == ST_FULL) && out_ready) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ptr_upd) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb/tb_reg_rr_arbiter.sv - self-checking bench: behavioural model compare plus directed literal checks
module tb_reg_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    reg_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the output register must hold according to the arbitration rules.
    bit           m_live = 1'b0;
    bit           m_full = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_id   = 0;
    int           m_ptr  = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] m;
        m = v;
`ifdef REG_RR_ARBITER_PRIO0_EN
        if (m[0]) return 0;
        m[0] = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (rst || (m_full && !out_ready)) return '0;
        w = pick(req_valid, m_ptr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_live = 1'b1;
            m_full = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_ptr  = 0;
        end else begin
            w = pick(req_valid, m_ptr);
            if ((!m_full || out_ready) && w >= 0) begin
                m_full = 1'b1;
                m_data = req_data[w*W +: W];
                m_id   = w;
`ifdef REG_RR_ARBITER_PRIO0_EN
                if (w != 0) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_out_valid", 64'(out_valid), 64'(m_full));
            chk("model_out_data", 64'(out_data), 64'(m_data));
            chk("model_out_id", 64'(out_id), 64'(m_id));
            chk("model_req_ready", 64'(req_ready), 64'(exp_ready()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

`ifdef REG_RR_ARBITER_PRIO0_EN
    int seq_all[6] = '{0, 0, 0, 0, 0, 0};
    int seq_wrap[2] = '{0, 0};
    int seq_pair[4] = '{0, 0, 0, 0};
`else
    int seq_all[6] = '{0, 1, 2, 3, 0, 1};
    int seq_wrap[2] = '{3, 0};
    int seq_pair[4] = '{0, 1, 0, 1};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        repeat (5) begin
            cyc();
            chk("idle_out_valid", 64'(out_valid), 64'(0));
            chk("idle_req_ready", 64'(req_ready), 64'(0));
            chk("idle_out_data", 64'(out_data), 64'(0));
        end

        for (int i = 0; i < N; i++) set_data(i, W'(32'h10 + i));
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_out_valid", 64'(out_valid), 64'(1));
            chk("rr_out_id", 64'(out_id), 64'(seq_all[k]));
            chk("rr_out_data", 64'(out_data), 64'(32'h10 + seq_all[k]));
        end
        req_valid = '0;
        cyc();
        chk("drain_out_valid", 64'(out_valid), 64'(0));

        set_data(2, 32'hCAFE);
        req_valid = 4'b0100;
        out_ready = 1'b0;
        cyc();
        chk("stall_load_valid", 64'(out_valid), 64'(1));
        chk("stall_load_id", 64'(out_id), 64'(2));
        repeat (3) begin
            cyc();
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_out_data", 64'(out_data), 64'(32'hCAFE));
            chk("stall_req_ready", 64'(req_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("release_req_ready", 64'(req_ready), 64'(4'b0100));
        cyc();
        chk("release_out_data", 64'(out_data), 64'(32'hCAFE));
        req_valid = '0;
        cyc();
        chk("release_drain", 64'(out_valid), 64'(0));

        set_data(0, 32'hA000);
        set_data(3, 32'hA003);
        req_valid = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("wrap_out_id", 64'(out_id), 64'(seq_wrap[k]));
        end
        req_valid = '0;
        cyc();

        set_data(1, 32'hBEEF);
        req_valid = 4'b0010;
        out_ready = 1'b0;
        cyc();
        chk("beef_out_data", 64'(out_data), 64'(32'hBEEF));
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_id", 64'(out_id), 64'(0));
        rst = 1'b0;
        req_valid = 4'b1010;
        set_data(3, 32'hD003);
        out_ready = 1'b1;
        cyc();
        chk("post_rst_winner", 64'(out_id), 64'(1));
        chk("post_rst_data", 64'(out_data), 64'(32'hBEEF));

        rst = 1'b1;
        req_valid = '0;
        cyc();
        rst = 1'b0;
        set_data(0, 32'h50);
        set_data(1, 32'h51);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("pair_out_id", 64'(out_id), 64'(seq_pair[k]));
            chk("pair_out_data", 64'(out_data), 64'(32'h50 + seq_pair[k]));
        end
        req_valid = '0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_rr_arbiter.md
REG_RR_ARBITER -- requirements
Module: reg_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester valid.
REQ-006 SHALL have port req_data, input, NUM_REQ*DATA_W, requester i payload in bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_ready, output, NUM_REQ, per-requester accept, combinational, one-hot or zero.
REQ-008 SHALL have port out_valid, output, 1, output register holds a transfer.
REQ-009 SHALL have port out_data, output, DATA_W, registered payload.
REQ-010 SHALL have port out_id, output, $clog2(NUM_REQ), index of the requester that supplied out_data.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-012 SHALL implement a two-state output register FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load = (EMPTY or out_ready) and any req_valid bit set.
REQ-014 SHALL on load capture the winner's payload into out_data and its index into out_id, and enter FULL.
REQ-015 SHALL in FULL with out_ready=1 and no req_valid enter EMPTY; out_data/out_id keep their last values.
REQ-016 SHALL in FULL with out_ready=0 hold out_valid, out_data and out_id stable and keep req_ready all zero.
REQ-017 SHALL assert req_ready[i] only when load=1 and i is the winner; a transfer completes when req_valid[i] and req_ready[i] are both 1.
REQ-018 SHALL pick the winner round-robin: scan from pointer ptr upward, wrapping NUM_REQ-1 to 0; first set req_valid wins.
REQ-019 SHALL set ptr to (winner+1) mod NUM_REQ on every load; ptr SHALL be unchanged on cycles without load.
REQ-020 SHALL have a latency of one cycle from accepted request to out_valid, and sustain one transfer per cycle while out_ready=1.
REQ-021 SHALL, on a FULL cycle with out_ready=1 and a valid request, drain and refill in the same cycle (out_valid stays 1).
REQ-022 SHALL never drop, duplicate or reorder an accepted payload.

Reset
REQ-023 SHALL on rst=1 at a clock edge set out_valid=0, out_data=0, out_id=0, ptr=0, state EMPTY.
REQ-024 SHALL hold req_ready all zero while rst=1, regardless of req_valid.
REQ-025 SHALL discard a FULL payload when rst asserts mid-operation; no transfer is reported for it.

Configuration
REQ-026 SHALL, when macro REG_RR_ARBITER_PRIO0_EN is defined, give requester 0 strict priority: req_valid[0]=1 wins every load; round-robin applies only among 1..NUM_REQ-1, and ptr is updated only on non-zero wins.
REQ-027 SHALL, when REG_RR_ARBITER_PRIO0_EN is undefined, treat all requesters equally per REQ-018/REQ-019.

Structure
REQ-028 SHALL place NUM_REQ/DATA_W defaults and the requester-index typedef in shared package arb_pkg.
REQ-029 SHALL implement the winner search as combinational sub-module rr_pick (inputs req mask and ptr, outputs winner index and any-valid).
REQ-030 SHALL implement the output register and ptr with synchronous-reset, enabled flops only.

Verification
REQ-031 SHALL check: reset, then req_valid=4'b0000 for 5 cycles -> out_valid=0, req_ready=0, out_data=0 throughout.
REQ-032 SHALL check: all four valid continuously, data i=0x10+i, out_ready=1 -> out_id sequence 0,1,2,3,0,1, one per cycle, out_data matches.
REQ-033 SHALL check: req_valid=4'b0100 data 0xCAFE, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xCAFE stable, req_ready=0 during stall; transfer accepted on the first cycle after out_ready=1.
REQ-034 SHALL check: ptr=3 with req_valid=4'b1001 -> winner 3, then 0; ptr wrap verified.
REQ-035 SHALL check: rst asserted while FULL (out_data=0xBEEF) -> next cycle out_valid=0, out_data=0, ptr=0, first post-reset winner is lowest valid index.
REQ-036 SHALL check with REG_RR_ARBITER_PRIO0_EN: req_valid=4'b0011 for 4 cycles -> out_id 0,0,0,0; with macro undefined -> 0,1,0,1.
